// File: rtl/user_space.sv
// user_space: two identical toy cores behind a simple request/busy bus.
// Each core owns a word-addressed SRAM, a PC/INSTR pair, a run flag and
// an instret counter. Only JAL changes control flow; every other
// instruction behaves as a NOP.

module user_space_core #(
  parameter int          SRAM_WORDS  = 256,
  parameter logic [11:0] SRAM_REGION = 12'h300,
  parameter logic [11:0] REGS_REGION = 12'h308
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        access,
  input  logic [31:0] address,
  input  logic [3:0]  byte_select,
  input  logic        write_enable,
  input  logic [31:0] data_write,
  output logic        hit,
  output logic [31:0] rdata
);

  localparam int          AW          = $clog2(SRAM_WORDS);
  localparam logic [11:0] CSR_INSTRET = 12'hC02;

  logic [31:0] mem [SRAM_WORDS];

  logic        run_reg, run_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instret_reg, instret_next;

  logic          sel_sram, sel_regs;
  logic [19:0]   offset;
  logic [AW-1:0] bus_idx;
  logic          reg_we, cfg_we, jump_we, step_we;
  logic          sram_we, stall;
  logic          in_csr_window;
  logic [11:0]   csr_index;
  logic [31:0]   bus_word;

  logic          is_jal;
  logic [31:0]   jal_imm;
  logic [31:0]   run_target;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_word;
  logic          advance, retire;

  // Address decode for this core's SRAM and register windows.
  assign sel_sram      = (address[31:20] == SRAM_REGION);
  assign sel_regs      = (address[31:20] == REGS_REGION);
  assign offset        = address[19:0];
  assign bus_idx       = address[AW+1:2];
  assign in_csr_window = (offset[19:14] == 6'b000010) && (offset[1:0] == 2'b00);
  assign csr_index     = offset[13:2];

  // Register writes need at least one byte lane, SRAM writes go lane by lane.
  assign reg_we  = access && sel_regs && write_enable && (|byte_select);
  assign cfg_we  = reg_we && (offset == 20'h00000);
  assign jump_we = reg_we && (offset == 20'h00014);
  assign step_we = reg_we && (offset == 20'h00018);
  assign sram_we = access && sel_sram && write_enable;
  assign stall   = access && sel_sram;

  // JAL: J-type immediate, target relative to the address of the JAL itself,
  // which is PC-4 because PC already points past the fetched instruction.
  assign is_jal     = (instr_reg[6:0] == 7'h6F);
  assign jal_imm    = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                       instr_reg[20], instr_reg[30:21], 1'b0};
  assign run_target = is_jal ? ((pc_reg - 32'd4) + jal_imm) : pc_reg;

  // Byte-lane SRAM writes from the bus; contents survive reset.
  always_ff @(posedge clk) begin
    if (sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_select[b]) begin
          mem[bus_idx][8*b +: 8] <= data_write[8*b +: 8];
        end
      end
    end
  end

  assign bus_word   = mem[bus_idx];
  assign fetch_word = mem[fetch_addr[AW+1:2]];

  // Select the fetch address: JUMP beats STEP beats a normal run cycle.
  always_comb begin
    fetch_addr = pc_reg;
    advance    = 1'b0;
    retire     = 1'b0;
    if (jump_we) begin
      fetch_addr = {data_write[31:2], 2'b00};
      advance    = 1'b1;
    end else if (step_we) begin
      advance    = 1'b1;
    end else if (run_reg && !stall) begin
      fetch_addr = run_target;
      advance    = 1'b1;
      retire     = 1'b1;
    end
  end

  // Next values of the architectural state.
  always_comb begin
    run_next     = cfg_we ? data_write[0] : run_reg;
    pc_next      = advance ? (fetch_addr + 32'd4) : pc_reg;
    instr_next   = advance ? fetch_word : instr_reg;
    instret_next = retire ? (instret_reg + 32'd1) : instret_reg;
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg     <= 1'b0;
      pc_reg      <= '0;
      instr_reg   <= '0;
      instret_reg <= '0;
    end else begin
      run_reg     <= run_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      instret_reg <= instret_next;
    end
  end

  // Bus read view of this core; anything not readable returns all ones.
  always_comb begin
    hit   = sel_sram | sel_regs;
    rdata = 32'hFFFF_FFFF;
    if (sel_sram) begin
      rdata = bus_word;
    end else if (sel_regs) begin
      case (offset)
        20'h00000: rdata = {31'd0, run_reg};
        20'h00010: rdata = pc_reg;
        20'h0001C: rdata = instr_reg;
        default: begin
          if (in_csr_window) begin
            rdata = (csr_index == CSR_INSTRET) ? instret_reg : 32'd0;
          end
        end
      endcase
    end
  end

endmodule

module user_space #(
  parameter int MPRJ_IO_PADS = 38,
  parameter int SRAM_WORDS   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             wbAddress,
  input  logic [3:0]              wbByteSelect,
  input  logic                    wbEnable,
  input  logic                    wbWriteEnable,
  input  logic [31:0]             wbDataWrite,
  output logic [31:0]             wbDataRead,
  output logic                    wbBusy,
  input  logic                    succesOutput,
  input  logic                    nextTestOutput,
  input  logic [127:0]            la_data_in_user,
  output logic [127:0]            la_data_out_user,
  input  logic [127:0]            la_oenb_user,
  input  logic [MPRJ_IO_PADS-1:0] user_io_in,
  output logic [MPRJ_IO_PADS-1:0] user_io_out,
  output logic [MPRJ_IO_PADS-1:0] user_io_oeb,
  inout  wire  [MPRJ_IO_PADS-10:0] mprj_analog_io,
  output logic [2:0]              user_irq_core
);

  typedef enum logic [1:0] {BUS_IDLE, BUS_ACCESS, BUS_DONE} bus_state_t;

  bus_state_t       state_reg, state_next;
  logic             access;
  logic [31:0]      data_read_reg;
  logic [31:0]      bus_rdata;
  logic [1:0]       core_hit;
  logic [1:0][31:0] core_rdata;
  logic             unused_inputs;

  assign la_data_out_user = {126'd0, nextTestOutput, succesOutput};
  assign user_io_out      = '0;
  assign user_io_oeb      = '1;
  assign user_irq_core    = 3'b000;
  assign unused_inputs    = ^{la_data_in_user, la_oenb_user, user_io_in, mprj_analog_io};

  // Bus handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BUS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Handshake sequencing; the access strobe is withheld during reset so an
  // interrupted transaction has no side effects.
  always_comb begin
    state_next = state_reg;
    wbBusy     = 1'b0;
    access     = 1'b0;
    case (state_reg)
      BUS_IDLE: begin
        wbBusy = wbEnable;
        if (wbEnable) state_next = BUS_ACCESS;
      end
      BUS_ACCESS: begin
        wbBusy     = 1'b1;
        access     = !rst;
        state_next = BUS_DONE;
      end
      BUS_DONE: begin
        if (!wbEnable) state_next = BUS_IDLE;
      end
      default: state_next = BUS_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_core
      user_space_core #(
        .SRAM_WORDS  (SRAM_WORDS),
        .SRAM_REGION (12'h300 + 12'(gi)),
        .REGS_REGION (12'h308 + 12'(gi))
      ) u_core (
        .clk          (clk),
        .rst          (rst),
        .access       (access),
        .address      (wbAddress),
        .byte_select  (wbByteSelect),
        .write_enable (wbWriteEnable),
        .data_write   (wbDataWrite),
        .hit          (core_hit[gi]),
        .rdata        (core_rdata[gi])
      );
    end
  endgenerate

  // Route the addressed core's read view; unclaimed addresses read all ones.
  always_comb begin
    bus_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      if (core_hit[c]) bus_rdata = core_rdata[c];
    end
  end

  // Capture read data at the end of the access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_read_reg <= '0;
    end else if (access && !wbWriteEnable) begin
      data_read_reg <= bus_rdata;
    end
  end

  assign wbDataRead = data_read_reg;

endmodule

// File: tb/tb_user_space.sv
// Bench for user_space: randomized bus traffic against a cycle-level
// behavioural model of both cores, plus directed scenarios with literal
// expectations.

module tb_user_space;

  localparam int PADS = 38;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       wbAddress;
  logic [3:0]        wbByteSelect;
  logic              wbEnable;
  logic              wbWriteEnable;
  logic [31:0]       wbDataWrite;
  logic [31:0]       wbDataRead;
  logic              wbBusy;
  logic              succesOutput;
  logic              nextTestOutput;
  logic [127:0]      la_data_in_user;
  logic [127:0]      la_data_out_user;
  logic [127:0]      la_oenb_user;
  logic [PADS-1:0]   user_io_in;
  logic [PADS-1:0]   user_io_out;
  logic [PADS-1:0]   user_io_oeb;
  wire  [PADS-10:0]  mprj_analog_io;
  logic [2:0]        user_irq_core;

  always #5 clk = ~clk;

  user_space #(.MPRJ_IO_PADS(PADS), .SRAM_WORDS(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .wbAddress        (wbAddress),
    .wbByteSelect     (wbByteSelect),
    .wbEnable         (wbEnable),
    .wbWriteEnable    (wbWriteEnable),
    .wbDataWrite      (wbDataWrite),
    .wbDataRead       (wbDataRead),
    .wbBusy           (wbBusy),
    .succesOutput     (succesOutput),
    .nextTestOutput   (nextTestOutput),
    .la_data_in_user  (la_data_in_user),
    .la_data_out_user (la_data_out_user),
    .la_oenb_user     (la_oenb_user),
    .user_io_in       (user_io_in),
    .user_io_out      (user_io_out),
    .user_io_oeb      (user_io_oeb),
    .mprj_analog_io   (mprj_analog_io),
    .user_irq_core    (user_irq_core)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic check_true(input string name, input bit cond, input logic [31:0] val);
    checks_total++;
    if (cond) checks_passed++;
    else $display("FAIL %s: got %h, required condition not met", name, val);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_ACCESS, P_DONE} phase_t;
  phase_t      m_phase;
  logic [31:0] m_mem [2][256];
  bit          m_run [2];
  logic [31:0] m_pc [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_instret [2];
  logic [31:0] m_rd;
  bit          m_valid = 0;

  function automatic logic [31:0] sram_base(input int c);
    return 32'h3000_0000 + 32'(c) * 32'h0010_0000;
  endfunction

  function automatic logic [31:0] regs_base(input int c);
    return 32'h3080_0000 + 32'(c) * 32'h0010_0000;
  endfunction

  function automatic bit is_sram(input logic [31:0] a, input int c);
    return (a & 32'hFFF0_0000) == sram_base(c);
  endfunction

  function automatic bit is_regs(input logic [31:0] a, input int c);
    return (a & 32'hFFF0_0000) == regs_base(c);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd256);
  endfunction

  // Signed J-immediate built arithmetically from the instruction fields.
  function automatic logic [31:0] jal_offset(input logic [31:0] i);
    int v;
    v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
    if (i[31]) v = v - (1 << 20);
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] res;
    logic [31:0] off;
    res = 32'hFFFF_FFFF;
    off = a & 32'h000F_FFFF;
    for (int c = 0; c < 2; c++) begin
      if (is_sram(a, c)) res = m_mem[c][word_of(a)];
      if (is_regs(a, c)) begin
        if (off == 32'h0)       res = {31'd0, m_run[c]};
        else if (off == 32'h10) res = m_pc[c];
        else if (off == 32'h1C) res = m_instr[c];
        else if (off >= 32'h8000 && off < 32'hC000 && off % 4 == 0)
          res = ((off - 32'h8000) / 4 == 32'hC02) ? m_instret[c] : 32'd0;
      end
    end
    return res;
  endfunction

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    bit          stall [2];
    bit          jump [2];
    bit          step [2];
    bit          cfg [2];
    logic [31:0] off;
    logic [31:0] tgt;
    if (rst) begin
      m_phase = P_IDLE;
      m_rd    = 32'd0;
      for (int c = 0; c < 2; c++) begin
        m_run[c] = 0; m_pc[c] = 0; m_instr[c] = 0; m_instret[c] = 0;
      end
      m_valid = 1;
    end else begin
      off = wbAddress & 32'h000F_FFFF;
      for (int c = 0; c < 2; c++) begin
        stall[c] = 0; jump[c] = 0; step[c] = 0; cfg[c] = 0;
      end
      if (m_phase == P_ACCESS) begin
        if (!wbWriteEnable) m_rd = model_read(wbAddress);
        for (int c = 0; c < 2; c++) begin
          if (is_sram(wbAddress, c)) begin
            stall[c] = 1;
            if (wbWriteEnable) begin
              for (int b = 0; b < 4; b++)
                if (wbByteSelect[b])
                  m_mem[c][word_of(wbAddress)][8*b +: 8] = wbDataWrite[8*b +: 8];
            end
          end
          if (is_regs(wbAddress, c) && wbWriteEnable && wbByteSelect != 4'b0000) begin
            cfg[c]  = (off == 32'h0);
            jump[c] = (off == 32'h14);
            step[c] = (off == 32'h18);
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (jump[c]) begin
          tgt = wbDataWrite & ~32'd3;
          m_instr[c] = m_mem[c][word_of(tgt)];
          m_pc[c]    = tgt + 4;
        end else if (step[c]) begin
          m_instr[c] = m_mem[c][word_of(m_pc[c])];
          m_pc[c]    = m_pc[c] + 4;
        end else if (m_run[c] && !stall[c]) begin
          tgt = m_pc[c];
          if (m_instr[c][6:0] == 7'h6F) tgt = m_pc[c] - 4 + jal_offset(m_instr[c]);
          m_instr[c]   = m_mem[c][word_of(tgt)];
          m_pc[c]      = tgt + 4;
          m_instret[c] = m_instret[c] + 1;
        end
        if (cfg[c]) m_run[c] = wbDataWrite[0];
      end
      case (m_phase)
        P_IDLE:   if (wbEnable) m_phase = P_ACCESS;
        P_ACCESS: m_phase = P_DONE;
        default:  if (!wbEnable) m_phase = P_IDLE;
      endcase
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", wbBusy, (m_phase == P_IDLE) ? wbEnable : (m_phase == P_ACCESS));
      check("data_read", wbDataRead, m_rd);
      check("la_out", la_data_out_user, {126'd0, nextTestOutput, succesOutput});
      check("io_out_oeb", {user_io_out, user_io_oeb}, {{PADS{1'b0}}, {PADS{1'b1}}});
      check("irq", user_irq_core, 3'b000);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    succesOutput   = 1'($urandom);
    nextTestOutput = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                     input logic [31:0] d, output logic [31:0] r);
    int n;
    wbAddress = a; wbWriteEnable = we; wbByteSelect = be; wbDataWrite = d; wbEnable = 1'b1;
    cycle();
    n = 0;
    while (wbBusy === 1'b1 && n < 8) begin
      cycle();
      n++;
    end
    check("bus_complete", wbBusy, 1'b0);
    r = wbDataRead;
    $display("txn %s addr=%h be=%b wdata=%h rdata=%h", we ? "WR" : "RD", a, be, d, r);
    wbEnable = 1'b0;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, v, a, ret1, ret2;
    int          k, c;
    logic        we;
    logic [3:0]  be;

    rst = 1'b1; wbEnable = 1'b0; wbAddress = '0; wbByteSelect = '0;
    wbWriteEnable = 1'b0; wbDataWrite = '0; succesOutput = 1'b0; nextTestOutput = 1'b0;
    la_data_in_user = '0; la_oenb_user = '1; user_io_in = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset_data_read", wbDataRead, 32'd0);
    check("reset_busy", wbBusy, 1'b0);

    // Fill both SRAMs with random words, roughly a quarter of them JALs.
    for (int ci = 0; ci < 2; ci++) begin
      for (int w = 0; w < 256; w++) begin
        v = $urandom;
        if ($urandom_range(3) == 0) v[6:0] = 7'h6F;
        else if (v[6:0] == 7'h6F) v[6:0] = 7'h13;
        bus(sram_base(ci) + 32'(w) * 4, 1'b1, 4'hF, v, r);
      end
    end

    for (int ci = 0; ci < 2; ci++) begin
      bus(sram_base(ci), 1'b1, 4'hF, 32'h0000_0013, r);
      bus(sram_base(ci), 1'b0, 4'hF, 32'd0, r);
      check("sram_word0_readback", r, 32'h0000_0013);
    end

    bus(regs_base(0), 1'b0, 4'hF, 32'd0, r);
    check("core0_config_after_reset", r, 32'd0);
    bus(regs_base(0) + 32'h10, 1'b0, 4'hF, 32'd0, r);
    check("core0_pc_after_reset", r, 32'd0);
    bus(regs_base(0) + 32'h18, 1'b1, 4'hF, 32'h1234_5678, r);
    bus(regs_base(0) + 32'h10, 1'b0, 4'hF, 32'd0, r);
    check("core0_pc_after_step", r, 32'h4);
    bus(regs_base(0) + 32'h1C, 1'b0, 4'hF, 32'd0, r);
    check("core0_instr_after_step", r, 32'h0000_0013);

    // Tight JAL loop at words 0x40..0x42 on each core in turn.
    for (int ci = 0; ci < 2; ci++) begin
      bus(sram_base(ci) + 32'h100, 1'b1, 4'hF, 32'h0000_0013, r);
      bus(sram_base(ci) + 32'h104, 1'b1, 4'hF, 32'h0000_0013, r);
      bus(sram_base(ci) + 32'h108, 1'b1, 4'hF, 32'hFFDF_F06F, r);
      bus(regs_base(ci) + 32'h14, 1'b1, 4'hF, 32'h0000_0100, r);
      bus(regs_base(ci) + 32'h10, 1'b0, 4'hF, 32'd0, r);
      check("jump_pc", r, 32'h104);
      bus(regs_base(ci) + 32'h1C, 1'b0, 4'hF, 32'd0, r);
      check("jump_instr", r, 32'h0000_0013);
      bus(regs_base(ci), 1'b1, 4'hF, 32'h1, r);
      idle(8);
      bus(regs_base(ci), 1'b1, 4'hF, 32'h0, r);
      bus(regs_base(ci), 1'b0, 4'hF, 32'd0, r);
      check("halted_config", r, 32'd0);
      bus(regs_base(ci) + 32'hB008, 1'b0, 4'hF, 32'd0, r);
      ret1 = r;
      check_true("instret_after_run", (r > 32'd1) && (r != 32'hFFFF_FFFF), r);
      bus(regs_base(ci) + 32'h10, 1'b0, 4'hF, 32'd0, r);
      check_true("pc_in_loop", (r == 32'h108) || (r == 32'h10C), r);
      bus(regs_base(ci), 1'b1, 4'hF, 32'h1, r);
      idle(8);
      bus(regs_base(ci), 1'b1, 4'hF, 32'h0, r);
      bus(regs_base(ci) + 32'hB008, 1'b0, 4'hF, 32'd0, r);
      ret2 = r;
      check_true("instret_grows_on_rerun", ret2 > ret1, ret2);
    end
    bus(regs_base(0) + 32'hB008, 1'b0, 4'hF, 32'd0, r);
    check("core0_instret_kept", r, m_instret[0]);
    bus(regs_base(0) + 32'h10, 1'b0, 4'hF, 32'd0, r);
    check("core0_pc_kept", r, m_pc[0]);

    bus(32'h3070_0000, 1'b0, 4'hF, 32'd0, r);
    check("unmapped_read", r, 32'hFFFF_FFFF);
    bus(sram_base(0) + 32'h14, 1'b1, 4'hF, 32'h1122_3344, r);
    bus(sram_base(0) + 32'h14, 1'b1, 4'b0001, 32'h0000_00AA, r);
    bus(sram_base(0) + 32'h14, 1'b0, 4'hF, 32'd0, r);
    check("byte_lane_write", r, 32'h1122_33AA);

    // Random traffic; the per-cycle compare process checks every result.
    for (int t = 0; t < 400; t++) begin
      k  = $urandom_range(11);
      c  = $urandom_range(1);
      v  = $urandom;
      we = 1'($urandom);
      be = 4'($urandom);
      case (k)
        0, 1:    a = sram_base(c) + 32'($urandom_range(1023)) * 4;
        2, 3:    a = regs_base(c);
        4:       a = regs_base(c) + 32'h10;
        5:       a = regs_base(c) + 32'h14;
        6:       a = regs_base(c) + 32'h18;
        7:       a = regs_base(c) + 32'h1C;
        8:       a = regs_base(c) + 32'hB008;
        9:       a = regs_base(c) + 32'h8000 + 32'($urandom_range(4095)) * 4;
        10:      a = regs_base(c) + 32'h11;
        default: a = 32'h3070_0000 + 32'($urandom_range(255)) * 4;
      endcase
      bus(a, we, be, v, r);
      idle($urandom_range(3));
    end

    // Reset in the middle of an SRAM write must abort it.
    wbAddress = sram_base(0) + 32'h1C; wbWriteEnable = 1'b1; wbByteSelect = 4'hF;
    wbDataWrite = ~m_mem[0][7]; wbEnable = 1'b1;
    cycle();
    rst = 1'b1; wbEnable = 1'b0;
    cycle();
    check("reset_abort_busy", wbBusy, 1'b0);
    rst = 1'b0;
    cycle();
    bus(sram_base(0) + 32'h1C, 1'b0, 4'hF, 32'd0, r);
    check("reset_abort_no_write", r, m_mem[0][7]);
    bus(regs_base(1) + 32'h10, 1'b0, 4'hF, 32'd0, r);
    check("core1_pc_after_reset", r, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/user_space.md
USER_SPACE -- requirements
Module: UserSpace

Interface
REQ-001 SHALL have parameter MPRJ_IO_PADS, default 38, number of user IO pads.
REQ-002 SHALL have parameter SRAM_WORDS, default 256, 32-bit words of SRAM per core (1 KB).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wbAddress  in  32  byte address of bus request.
REQ-007 wbByteSelect  in  4  byte lanes for SRAM writes.
REQ-008 wbEnable  in  1  request; master holds it high until wbBusy falls.
REQ-009 wbWriteEnable  in  1  1=write, 0=read.
REQ-010 wbDataWrite  in  32  write data.
REQ-011 wbDataRead  out  32  read data; valid when wbBusy falls.
REQ-012 wbBusy  out  1  transaction in progress.
REQ-013 succesOutput, nextTestOutput  in  1 each  test status flags.
REQ-014 la_data_in_user, la_oenb_user  in  128 each  unused.
REQ-015 la_data_out_user  out  128  bit0=succesOutput, bit1=nextTestOutput, others 0.
REQ-016 user_io_in  in  MPRJ_IO_PADS  unused; user_io_out  out  MPRJ_IO_PADS  all 0; user_io_oeb  out  MPRJ_IO_PADS  all 1.
REQ-017 mprj_analog_io  inout  MPRJ_IO_PADS-9  undriven (high-Z).
REQ-018 user_irq_core  out  3  constant 0.

Function
REQ-019 Address map: core0 SRAM 0x3000_0000, core1 SRAM 0x3010_0000 (word index addr[9:2]); core0 regs 0x3080_0000, core1 regs 0x3090_0000.
REQ-020 Reg offsets: CONFIG 0x0 (R/W, bit0 run, other bits read 0), PC 0x10 (R), JUMP 0x14 (W), STEP 0x18 (W, data ignored), INSTR 0x1C (R), CSR window 0x8000+4*csr (R).
REQ-021 CSR 0xC02 (instret) SHALL return the 32-bit executed-instruction count; all other CSRs read 0.
REQ-022 Unmapped reads SHALL return 0xFFFF_FFFF; unmapped or read-only writes SHALL be ignored.
REQ-023 Bus FSM IDLE->ACCESS->DONE: in IDLE wbBusy=wbEnable (combinational); ACCESS: wbBusy=1, access performed, read data latched into wbDataRead; DONE: wbBusy=0, stay until wbEnable=0, then IDLE.
REQ-024 SRAM writes SHALL honour wbByteSelect per byte; register writes SHALL occur when any select bit is set.
REQ-025 SRAM read is asynchronous; a bus SRAM access in ACCESS stalls that core for that cycle.
REQ-026 STEP: INSTR<=mem[PC]; PC<=PC+4; instret unchanged.
REQ-027 JUMP value J: INSTR<=mem[J&~3]; PC<=(J&~3)+4.
REQ-028 Run (CONFIG bit0=1), every non-stalled cycle: A = INSTR is JAL (opcode 0x6F) ? (PC-4)+sext(J-imm) : PC; INSTR<=mem[A]; PC<=A+4; instret+=1 (wraps).
REQ-029 All non-JAL instructions SHALL execute as NOP; JAL rd writes are discarded.
REQ-030 STEP/JUMP writes SHALL take priority over a run cycle in the same clock.
REQ-031 PC and SRAM addressing SHALL wrap modulo SRAM size; PC register keeps full 32 bits.
REQ-032 Writing CONFIG=0 SHALL halt from the next cycle; PC, INSTR, instret retained; re-run continues from retained state.
REQ-033 Both cores SHALL be independent and identical.

Reset
REQ-034 On rst: CONFIG=0, PC=0, INSTR=0, instret=0, bus FSM IDLE, wbDataRead=0; SRAM contents not reset.
REQ-035 rst mid-transaction SHALL abort it; wbBusy low the cycle after rst while wbEnable=0.

Verification
REQ-036 Write 0x00000013 to core0 SRAM word 0, read back -> 0x00000013; same for core1.
REQ-037 After reset read core0 CONFIG -> 0, PC -> 0; write STEP -> PC 0x4, INSTR 0x00000013.
REQ-038 Write JUMP=0x100 -> PC reads 0x104, INSTR = mem word 0x40.
REQ-039 Words 0x40,0x41=NOP, 0x42=0xFFDFF06F (jal -4); jump 0x100, run 8 cycles, halt -> CONFIG 0, instret >1 and !=0xFFFFFFFF, PC in {0x108,0x10C}.
REQ-040 Re-run 8 cycles, halt -> instret strictly greater than before; repeat on core1, core0 state unchanged.
REQ-041 Read 0x3070_0000 -> 0xFFFFFFFF; byte write select 0001 of 0xAA to SRAM -> only byte0 changes.
